irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 23 ++
 rtl/irq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// CSR read/write port and interrupt handshake between the core and irq_ctrl.
// The core drives as master and irq_ctrl responds as slave.
interface irq_ctrl_if;
   logic [11:0] csr_addr;
   logic [1:0]  csr_write;
   logic [31:0] csr_data_in;
   logic [31:0] csr_data_out;
   logic        csr_hit;
   logic        csr_error;
   logic        irq_req;
   logic [4:0]  irq_cause;
   logic        irq_take;

   modport master (
      output csr_addr, csr_write, csr_data_in, irq_take,
      input  csr_data_out, csr_hit, csr_error, irq_req, irq_cause
   );

   modport slave (
      input  csr_addr, csr_write, csr_data_in, irq_take,
      output csr_data_out, csr_hit, csr_error, irq_req, irq_cause
   );
endinterface

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mie/mip CSRs, 64-bit mtime/mtimecmp timer,
// external IRQ synchronizer and a request/take handshake FSM toward writeback.
module irq_ctrl (
   input  logic       clk,
   input  logic       reset,
   irq_ctrl_if.slave  bus,
   input  logic       ext_irq,
   input  logic       mstatus_mie
);
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MIP     = 12'h344;
   localparam logic [11:0] ADDR_CMP_LO  = 12'h7C0;
   localparam logic [11:0] ADDR_CMP_HI  = 12'h7C1;
   localparam logic [11:0] ADDR_TIME_LO = 12'h7C2;
   localparam logic [11:0] ADDR_TIME_HI = 12'h7C3;
   localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
   localparam logic [4:0]  CAUSE_MSI    = 5'd3;
   localparam logic [4:0]  CAUSE_MTI    = 5'd7;
   localparam logic [4:0]  CAUSE_MEI    = 5'd11;
   localparam int          SYNC_STAGES  = 2;

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t                   state_reg, state_next;
   logic [4:0]               cause_reg, cause_next;
   logic [31:0]              mie_reg, mie_next;
   logic                     msip_reg, msip_next;
   logic                     mtip_reg;
   logic [63:0]              mtime_reg;
   logic [63:0]              mtimecmp_reg, mtimecmp_next;
   logic [SYNC_STAGES-1:0]   ext_sync_reg;

   logic        meip;
   logic [31:0] mip;
   logic [31:0] rd_val;
   logic        hit;
   logic        err;
   logic        wr_en;
   logic [31:0] wr_val;
   logic [31:0] pend;
   logic        pend_any;
   logic [4:0]  top_cause;

   assign meip = ext_sync_reg[SYNC_STAGES-1];
   assign mip  = {20'b0, meip, 3'b0, mtip_reg, 3'b0, msip_reg, 3'b0};

   // Read mux doubles as the address decoder; unmapped addresses read 0.
   always_comb begin
      rd_val = 32'h0;
      hit    = 1'b1;
      case (bus.csr_addr)
         ADDR_MIE:     rd_val = mie_reg;
         ADDR_MIP:     rd_val = mip;
         ADDR_CMP_LO:  rd_val = mtimecmp_reg[31:0];
         ADDR_CMP_HI:  rd_val = mtimecmp_reg[63:32];
         ADDR_TIME_LO: rd_val = mtime_reg[31:0];
         ADDR_TIME_HI: rd_val = mtime_reg[63:32];
         default:      hit    = 1'b0;
      endcase
   end

   assign err   = hit && (bus.csr_write != 2'b00)
                  && ((bus.csr_addr == ADDR_TIME_LO) || (bus.csr_addr == ADDR_TIME_HI));
   assign wr_en = hit && (bus.csr_write != 2'b00) && !err;

   always_comb begin
      wr_val = rd_val;
      case (bus.csr_write)
         2'b01:   wr_val = bus.csr_data_in;
         2'b10:   wr_val = rd_val | bus.csr_data_in;
         2'b11:   wr_val = rd_val & ~bus.csr_data_in;
         default: wr_val = rd_val;
      endcase
   end

   // Only MSIP is software-writable in mip; MTIP/MEIP track their sources.
   always_comb begin
      mie_next      = mie_reg;
      msip_next     = msip_reg;
      mtimecmp_next = mtimecmp_reg;
      if (wr_en) begin
         case (bus.csr_addr)
            ADDR_MIE:    mie_next = wr_val & MIE_MASK;
            ADDR_MIP:    msip_next = wr_val[3];
            ADDR_CMP_LO: mtimecmp_next[31:0] = wr_val;
            ADDR_CMP_HI: mtimecmp_next[63:32] = wr_val;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mie_reg      <= 32'h0;
         msip_reg     <= 1'b0;
         mtip_reg     <= 1'b0;
         mtime_reg    <= 64'h0;
         mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
         ext_sync_reg <= '0;
      end else begin
         mie_reg      <= mie_next;
         msip_reg     <= msip_next;
         mtip_reg     <= (mtime_reg >= mtimecmp_reg);
         mtime_reg    <= mtime_reg + 64'd1;
         mtimecmp_reg <= mtimecmp_next;
         ext_sync_reg <= {ext_sync_reg[SYNC_STAGES-2:0], ext_irq};
      end
   end

   assign pend     = mstatus_mie ? (mip & mie_reg) : 32'h0;
   assign pend_any = |pend;

   always_comb begin
      top_cause = 5'd0;
      if (pend[11])     top_cause = CAUSE_MEI;
      else if (pend[3]) top_cause = CAUSE_MSI;
      else if (pend[7]) top_cause = CAUSE_MTI;
   end

   // A take wins over a same-cycle withdrawal so the sampled cause is honoured.
   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      case (state_reg)
         IDLE: begin
            if (pend_any) begin
               state_next = REQ;
               cause_next = top_cause;
            end
         end
         REQ: begin
            if (bus.irq_take) begin
               state_next = HOLD;
            end else if (!pend_any) begin
               state_next = IDLE;
            end else begin
               cause_next = top_cause;
            end
         end
         HOLD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cause_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         cause_reg <= cause_next;
      end
   end

   assign bus.csr_data_out = rd_val;
   assign bus.csr_hit      = hit;
   assign bus.csr_error    = err;
   assign bus.irq_req      = (state_reg == REQ) && !reset;
   assign bus.irq_cause    = reset ? 5'd0 : cause_reg;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl: expectations are queued as stimulus is
// driven and popped when the matching DUT output is sampled on the falling edge.
module tb_irq_ctrl;
   logic clk;
   logic reset;
   logic ext_irq;
   logic mstatus_mie;
   logic [63:0] mtime_model;

   int checks;
   int failures;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   irq_ctrl_if bus ();

   irq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .ext_irq     (ext_irq),
      .mstatus_mie (mstatus_mie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference free-running timer.
   always @(posedge clk) begin
      if (reset) mtime_model <= 64'h0;
      else       mtime_model <= mtime_model + 64'd1;
   end

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h required=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         $display("[%0t] check %s observed=%h expected=%h", $time, t, obs, e);
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic req_chk(input string tag, input logic r, input logic [4:0] c,
                          input logic check_cause);
      push({tag, "_req"}, {31'b0, r});
      chk({31'b0, bus.irq_req});
      if (check_cause) begin
         push({tag, "_cause"}, {27'b0, c});
         chk({27'b0, bus.irq_cause});
      end
   endtask

   task automatic drive_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      bus.csr_addr    = a;
      bus.csr_write   = op;
      bus.csr_data_in = d;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      @(negedge clk);
      drive_wr(a, op, d);
      $display("[%0t] csr op=%0d addr=%h data=%h", $time, op, a, d);
      @(posedge clk);
      #1;
      bus.csr_write = 2'b00;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e);
      @(negedge clk);
      bus.csr_addr  = a;
      bus.csr_write = 2'b00;
      #1;
      push(tag, e);
      chk(bus.csr_data_out);
   endtask

   initial begin
      int guard;
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      ext_irq         = 1'b0;
      mstatus_mie     = 1'b0;
      bus.csr_addr    = 12'h0;
      bus.csr_write   = 2'b00;
      bus.csr_data_in = 32'h0;
      bus.irq_take    = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      req_chk("in_reset", 1'b0, 5'd0, 1'b1);

      // First cycle after reset
      @(negedge clk);
      reset        = 1'b0;
      bus.csr_addr = 12'h7C2;
      #1;
      push("mtime_after_reset", 32'h0);
      chk(bus.csr_data_out);
      req_chk("after_reset", 1'b0, 5'd0, 1'b1);
      rd_chk("cmp_lo_reset", 12'h7C0, 32'hFFFF_FFFF);
      rd_chk("cmp_hi_reset", 12'h7C1, 32'hFFFF_FFFF);
      rd_chk("mie_reset", 12'h304, 32'h0);
      rd_chk("mip_reset", 12'h344, 32'h0);
      rd_chk("nohit_data", 12'h305, 32'h0);
      push("nohit_hit", 32'h0);
      chk({31'b0, bus.csr_hit});

      // Timer interrupt
      wr(12'h7C1, 2'b01, 32'h0);
      wr(12'h7C0, 2'b01, 32'd20);
      wr(12'h304, 2'b01, 32'h80);
      rd_chk("cmp_lo_written", 12'h7C0, 32'd20);
      mstatus_mie = 1'b1;
      guard = 0;
      while (mtime_model != 64'd20 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (mtime_model != 64'd20) begin
         checks++;
         failures++;
         $error("FAIL timer_wait observed=%0d required=20", mtime_model);
      end
      #1;
      bus.csr_addr = 12'h344;
      #1;
      push("mip_at_mtime20", 32'h0);
      chk(bus.csr_data_out);
      @(negedge clk); #1;
      push("mip_at_mtime21", 32'h80);
      chk(bus.csr_data_out);
      req_chk("timer_pre", 1'b0, 5'd0, 1'b0);
      @(negedge clk); #1;
      req_chk("timer_req", 1'b1, 5'd7, 1'b1);
      bus.irq_take = 1'b1;
      @(posedge clk); #1;
      bus.irq_take = 1'b0;
      @(negedge clk); #1;
      req_chk("timer_hold", 1'b0, 5'd7, 1'b1);
      @(negedge clk); #1;
      req_chk("timer_idle", 1'b0, 5'd0, 1'b0);
      @(negedge clk); #1;
      req_chk("timer_rereq", 1'b1, 5'd7, 1'b1);
      wr(12'h7C1, 2'b01, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      #1;
      req_chk("timer_withdrawn", 1'b0, 5'd0, 1'b0);

      // mie write mask
      wr(12'h304, 2'b01, 32'hFFFF_FFFF);
      rd_chk("mie_mask", 12'h304, 32'h888);
      rd_chk("mip_quiet", 12'h344, 32'h0);

      // Priority: MSI first, then MEI once the synchronizer catches up
      @(negedge clk);
      drive_wr(12'h344, 2'b10, 32'h8);
      ext_irq = 1'b1;
      @(posedge clk); #1;
      bus.csr_write = 2'b00;
      @(negedge clk); #1;
      req_chk("prio_idle", 1'b0, 5'd0, 1'b0);
      @(negedge clk); #1;
      req_chk("prio_first", 1'b1, 5'd3, 1'b1);
      @(negedge clk); #1;
      req_chk("prio_switch", 1'b1, 5'd11, 1'b1);
      bus.irq_take = 1'b1;
      @(posedge clk); #1;
      bus.irq_take = 1'b0;
      @(negedge clk); #1;
      req_chk("prio_hold", 1'b0, 5'd11, 1'b1);
      @(negedge clk); #1;
      req_chk("prio_idle2", 1'b0, 5'd0, 1'b0);
      @(negedge clk); #1;
      req_chk("prio_rereq", 1'b1, 5'd11, 1'b1);

      // Withdrawal by clearing MSIP
      ext_irq = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      req_chk("wd_cause3", 1'b1, 5'd3, 1'b1);
      wr(12'h344, 2'b11, 32'h8);
      @(negedge clk); #1;
      req_chk("wd_landed", 1'b1, 5'd3, 1'b1);
      @(negedge clk); #1;
      req_chk("wd_dropped", 1'b0, 5'd0, 1'b0);

      // Global enable gate
      mstatus_mie = 1'b0;
      wr(12'h344, 2'b10, 32'h8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         req_chk("gate_off", 1'b0, 5'd0, 1'b0);
      end
      mstatus_mie = 1'b1;
      @(negedge clk); #1;
      req_chk("gate_on", 1'b1, 5'd3, 1'b1);

      // Take and clearing write in the same cycle
      @(negedge clk);
      drive_wr(12'h344, 2'b11, 32'h8);
      bus.irq_take = 1'b1;
      @(posedge clk); #1;
      bus.csr_write = 2'b00;
      bus.irq_take  = 1'b0;
      @(negedge clk); #1;
      req_chk("takeclr_hold", 1'b0, 5'd3, 1'b1);
      push("takeclr_mip", 32'h0);
      chk(bus.csr_data_out);
      @(negedge clk); #1;
      req_chk("takeclr_idle", 1'b0, 5'd0, 1'b0);
      @(negedge clk); #1;
      req_chk("takeclr_stay", 1'b0, 5'd0, 1'b0);

      // Illegal and read-only accesses
      @(negedge clk);
      drive_wr(12'h7C2, 2'b01, 32'h1234_5678);
      #1;
      push("err_flag", 32'h1);
      chk({31'b0, bus.csr_error});
      push("err_hit", 32'h1);
      chk({31'b0, bus.csr_hit});
      @(posedge clk); #1;
      bus.csr_write = 2'b00;
      @(negedge clk);
      bus.csr_addr = 12'h7C2;
      #1;
      push("mtime_kept", mtime_model[31:0]);
      chk(bus.csr_data_out);
      @(negedge clk);
      drive_wr(12'h7C3, 2'b10, 32'h1);
      #1;
      push("err_hi_set", 32'h1);
      chk({31'b0, bus.csr_error});
      @(posedge clk); #1;
      bus.csr_write = 2'b00;
      rd_chk("mtime_hi_kept", 12'h7C3, 32'h0);
      @(negedge clk);
      drive_wr(12'h344, 2'b01, 32'h880);
      #1;
      push("mip_ro_noerr", 32'h0);
      chk({31'b0, bus.csr_error});
      @(posedge clk); #1;
      bus.csr_write = 2'b00;
      rd_chk("mip_unchanged", 12'h344, 32'h0);

      // Reset while a request is active
      wr(12'h344, 2'b10, 32'h8);
      repeat (2) @(negedge clk);
      #1;
      req_chk("pre_rst", 1'b1, 5'd3, 1'b1);
      reset = 1'b1;
      #1;
      req_chk("rst_gate", 1'b0, 5'd0, 1'b1);
      @(negedge clk);
      reset        = 1'b0;
      bus.csr_addr = 12'h7C0;
      #1;
      push("rst_cmp_lo", 32'hFFFF_FFFF);
      chk(bus.csr_data_out);
      req_chk("rst_idle", 1'b0, 5'd0, 1'b1);
      rd_chk("rst_cmp_hi", 12'h7C1, 32'hFFFF_FFFF);
      rd_chk("rst_mip", 12'h344, 32'h0);
      rd_chk("rst_mie", 12'h304, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
